led_pattern_seq: RTL and testbench

Parametrised LED show sequencer driving an N-wide red LED bank and one green LED on the board demo path. It steps through up to five pattern phases: red blink, green blink, red chase, cross blink and rest. Each phase is individually enabled by a mask. Step rate, step count, LED width, chase direction, pause, one-shot/loop mode and run enable are all configurable. It also exposes its current phase and busy/done status to other logic.

---
 rtl/led_pattern_seq_pkg.sv | 23 ++
 rtl/led_pattern_seq_tick_divider.sv | 19 +
 rtl/led_pattern_seq.sv | 95 +++++++++
 tb/tb_led_pattern_seq.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/led_pattern_seq_pkg.sv
// led_pkg: phase codes, mask bit positions and phase-order helper for the LED show sequencer.
package led_pkg;
  typedef enum logic [2:0] {
    RED_BLINK   = 3'd0,
    GREEN_BLINK = 3'd1,
    RED_CHASE   = 3'd2,
    CROSS_BLINK = 3'd3,
    REST        = 3'd4,
    IDLE        = 3'd7
  } phase_e;
  localparam int MASK_RED_BLINK   = 0;
  localparam int MASK_GREEN_BLINK = 1;
  localparam int MASK_RED_CHASE   = 2;
  localparam int MASK_CROSS_BLINK = 3;
  localparam int MASK_REST        = 4;
  localparam phase_e PASS_END = IDLE;
  // Mask bit index equals phase code; from IDLE this yields the first enabled phase.
  function automatic phase_e next_phase(phase_e cur, logic [4:0] mask);
    next_phase = PASS_END;
    for (int i = MASK_REST; i >= MASK_RED_BLINK; i--)
      if (mask[i] && (cur == IDLE || i > int'(cur))) next_phase = phase_e'(3'(i));
  endfunction
endpackage

// File: rtl/led_pattern_seq_tick_divider.sv
// tick_divider: prescaler emitting one tick every TICK_DIV unheld cycles; clear restarts the count.
module tick_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick  = !clear && !hold && cnt_q == CW'(TICK_DIV - 1);
  assign cnt_d = (clear || tick) ? '0 : hold ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: phase-masked LED show sequencer (red blink, green blink, chase, cross blink, rest).
module led_pattern_seq
  import led_pkg::*;
#(
  parameter int NUM_RLEDS = 4,
  parameter int TICK_DIV  = 2**21,
  parameter int STEPS     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 pause,
  input  logic                 oneshot,
  input  logic                 chase_dir,
  input  logic [4:0]           phase_mask,
  output logic [NUM_RLEDS-1:0] rleds,
  output logic                 gled,
  output logic [2:0]           phase,
  output logic                 busy,
  output logic                 done
);
  localparam int SW = $clog2(STEPS);
  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);
  localparam logic [NUM_RLEDS-1:0] LSB = {{(NUM_RLEDS-1){1'b0}}, 1'b1};
  localparam logic [NUM_RLEDS-1:0] MSB = {1'b1, {(NUM_RLEDS-1){1'b0}}};
  phase_e phase_q, phase_d, tgt, first, nxt;
  logic [NUM_RLEDS-1:0] rleds_q, rleds_d, alt, rot;
  logic [SW-1:0] step_q, step_d;
  logic gled_q, gled_d, dir_q, dir_d, done_q, done_d, tick, load;
  for (genvar k = 0; k < NUM_RLEDS; k++) begin : g_alt
    assign alt[k] = (k % 2) == 0;
  end
  assign rot   = dir_q ? {rleds_q[NUM_RLEDS-2:0], rleds_q[NUM_RLEDS-1]}
                       : {rleds_q[0], rleds_q[NUM_RLEDS-1:1]};
  assign first = next_phase(IDLE, phase_mask);
  assign nxt   = next_phase(phase_q, phase_mask);
  assign busy  = phase_q != IDLE;
  assign phase = phase_q;
  assign rleds = rleds_q;
  assign gled  = gled_q;
  assign done  = done_q;
  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk(clk), .rst(rst), .clear(!busy || !en), .hold(pause), .tick(tick)
  );
  // en drops out first so it beats any tick or phase end; pause only gates the tick.
  always_comb begin
    phase_d = phase_q;
    rleds_d = rleds_q;
    gled_d  = gled_q;
    step_d  = step_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    load    = 1'b0;
    tgt     = IDLE;
    if (phase_q == IDLE) begin
      load = en && |phase_mask;
      tgt  = first;
    end else if (!en) begin
      load = 1'b1;
    end else if (tick && step_q == LAST) begin
      load   = 1'b1;
      tgt    = ~|phase_mask ? IDLE : nxt != PASS_END ? nxt : oneshot ? IDLE : first;
      done_d = |phase_mask && nxt == PASS_END && oneshot;
    end else if (tick) begin
      step_d  = step_q + 1'b1;
      rleds_d = (phase_q == RED_BLINK || phase_q == CROSS_BLINK) ? ~rleds_q
              : phase_q == RED_CHASE ? rot : rleds_q;
      gled_d  = phase_q == GREEN_BLINK ? ~gled_q : gled_q;
    end
    if (load) begin
      phase_d = tgt;
      step_d  = '0;
      dir_d   = tgt == RED_CHASE ? chase_dir : dir_q;
      rleds_d = tgt == RED_CHASE ? (chase_dir ? LSB : MSB) : tgt == CROSS_BLINK ? alt : '0;
      gled_d  = tgt == CROSS_BLINK;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= IDLE;
      rleds_q <= '0;
      gled_q  <= 1'b0;
      step_q  <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      rleds_q <= rleds_d;
      gled_q  <= gled_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: scoreboarded bench against an elapsed-time model of the LED show.
module tb_led_pattern_seq;
  localparam int N = 4, TD = 4, ST = 6, PL = TD * ST;
  logic clk = 0, rst = 1, en = 0, pause = 0, oneshot = 0, chase_dir = 0;
  logic [4:0] phase_mask = '0;
  logic [N-1:0] rleds;
  logic gled, busy, done;
  logic [2:0] phase;
  int checks = 0, errors = 0, cyc_n = 0;
  logic [9:0] expq[$];
  logic [9:0] exp_v, got_v;
  int m_ph = 7, m_el = 0;
  bit m_dir = 0, m_done = 0;
  led_pattern_seq #(.NUM_RLEDS(N), .TICK_DIV(TD), .STEPS(ST)) dut (
    .clk(clk), .rst(rst), .en(en), .pause(pause), .oneshot(oneshot), .chase_dir(chase_dir),
    .phase_mask(phase_mask), .rleds(rleds), .gled(gled), .phase(phase), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(string name, logic [9:0] got, logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %b expected %b ({rleds,gled,phase,busy,done})", name, cyc_n, got, exp);
    end
  endtask
  function automatic int enabled_after(logic [4:0] m, int after);
    for (int i = after + 1; i < 5; i++) if (m[i]) return i;
    return -1;
  endfunction
  task automatic enter(int p);
    m_ph = p;
    m_el = 0;
    if (p == 2) m_dir = chase_dir;
  endtask
  // Model tracks cycles spent in the phase; LED state follows from completed ticks.
  task automatic model_step();
    int nx;
    m_done = 0;
    if (rst) begin
      m_ph = 7;
      m_el = 0;
    end else if (m_ph == 7) begin
      if (en && phase_mask != 0) enter(enabled_after(phase_mask, -1));
    end else if (!en) begin
      m_ph = 7;
    end else if (!pause) begin
      m_el++;
      if (m_el == PL) begin
        nx = enabled_after(phase_mask, m_ph);
        if (phase_mask == 0) m_ph = 7;
        else if (nx >= 0) enter(nx);
        else if (oneshot) begin
          m_ph = 7;
          m_done = 1;
        end else enter(enabled_after(phase_mask, -1));
      end
    end
  endtask
  function automatic logic [9:0] expect_out();
    int k;
    logic [N-1:0] r;
    logic g;
    k = m_el / TD;
    r = '0;
    g = 0;
    case (m_ph)
      0: r = (k % 2 == 1) ? '1 : '0;
      1: g = k % 2 == 1;
      2: r = N'(1) << (m_dir ? k % N : N - 1 - k % N);
      3: begin
        r = (k % 2 == 1) ? 4'b1010 : 4'b0101;
        g = 1;
      end
      default: ;
    endcase
    return {r, g, 3'(m_ph), m_ph != 7, m_done};
  endfunction
  task automatic cyc(int n);
    repeat (n) begin
      model_step();
      expq.push_back(expect_out());
      @(negedge clk);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    cyc_n++;
    if (expq.size() != 0) begin
      exp_v = expq.pop_front();
      got_v = {rleds, gled, phase, busy, done};
      check("outputs", got_v, exp_v);
    end
  end
  initial begin
    cyc(3);
    rst = 0; en = 1; phase_mask = 5'b00001; oneshot = 1;
    cyc(30);
    en = 0; cyc(2);
    phase_mask = 5'b00100; chase_dir = 0; en = 1;
    cyc(26);
    en = 0; cyc(1);
    chase_dir = 1; en = 1;
    cyc(28);
    en = 0; cyc(1);
    phase_mask = 5'b11111; oneshot = 1; en = 1;
    cyc(125);
    en = 0; cyc(1);
    oneshot = 0; en = 1;
    cyc(250);
    en = 0; cyc(1);
    phase_mask = 5'b00001; oneshot = 1; en = 1;
    cyc(6);
    pause = 1; cyc(10);
    pause = 0; cyc(32);
    en = 0; cyc(1);
    phase_mask = 5'b00100; en = 1;
    cyc(9);
    rst = 1;
    #1;
    check("async_rst", {rleds, gled, phase, busy, done}, {4'b0000, 1'b0, 3'd7, 1'b0, 1'b0});
    cyc(2);
    rst = 0; cyc(12);
    en = 0; cyc(1);
    phase_mask = 5'b00010; en = 1;
    cyc(6);
    en = 0; cyc(2);
    phase_mask = 5'b00000; en = 1;
    cyc(5);
    repeat (200) begin
      en = $urandom_range(0, 9) != 0;
      pause = $urandom_range(0, 9) == 0;
      phase_mask = 5'($urandom);
      oneshot = 1'($urandom);
      chase_dir = 1'($urandom);
      rst = $urandom_range(0, 49) == 0;
      cyc($urandom_range(1, 30));
    end
    @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
